mips_branch_ctrl: RTL
=====================

Name: mips_branch_ctrl

Overview:
ID-stage branch sequencer for the 5-stage MIPS pipeline. Detects data hazards on branch operands and stalls IF/ID for the required number of cycles. Selects MEM-stage forwarding for the branch comparator, then issues the PC redirect and IF/ID flush once the branch comparator reports a taken BEQ. Sits between decode, the branch comparator and the pipeline register enables.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 2, stall counter width (maximum stall is 2 cycles)

Ports:
clk  input  1  core clock
rst_n  input  1  reset; synchronous, active-low
pipe_hold  input  1  global pipeline freeze (e.g. memory wait)
id_valid  input  1  ID stage holds a valid instruction
id_is_branch  input  1  ID instruction is a conditional branch
id_rs  input  REG_ADDR_W  branch operand A register
id_rt  input  REG_ADDR_W  branch operand B register
ex_reg_write  input  1  EX instruction writes a register
ex_mem_read  input  1  EX instruction is a load
ex_rd  input  REG_ADDR_W  EX destination register
mem_reg_write  input  1  MEM instruction writes a register
mem_mem_read  input  1  MEM instruction is a load
mem_rd  input  REG_ADDR_W  MEM destination register
beq_valid  input  1  comparator result: branch taken
stall_if_id  output  1  hold PC and IF/ID, inject bubble into ID/EX
flush_if_id  output  1  clear IF/ID at the next edge
pc_sel_branch  output  1  PC mux selects branch target
fwd_sel_a  output  2  comparator operand A source: 00 regfile, 01 MEM result
fwd_sel_b  output  2  same for operand B
br_state  output  2  current FSM state (debug)

Behaviour:
- Clock and reset are fixed: single clock clk; rst_n is synchronous and active-low.
- Reset, sampled on the clk edge with rst_n=0: FSM IDLE, counter 0. All outputs are 0 and br_state=IDLE. A reset mid-stall abandons the stall.
- Per-operand hazard count h(r). r=0 always gives 0.
  - EX writes r and is a load: 2.
  - EX writes r and is not a load: 1.
  - MEM writes r and is a load: 1.
  - Otherwise: 0.
  - EX match takes priority over MEM match.
- n = max(h(rs), h(rt)), evaluated only when id_valid & id_is_branch.
- Forwarding: fwd_sel_x=01 when MEM writes r (non-load, r≠0) and EX does not match r; otherwise 00. Forwarding is combinational in every state. The regfile is write-before-read, so WB needs no forward.
- FSM states: IDLE(0), STALL(1), RESOLVE(2).
  - IDLE, branch with n>0: stall_if_id=1 in this same cycle; counter←n-1; next state STALL if n=2, else RESOLVE.
  - IDLE, branch with n=0: the branch resolves this cycle and the FSM stays in IDLE.
  - STALL: stall_if_id=1; counter decrements; at 0 go to RESOLVE. Hazard inputs are ignored for the stall decision.
  - RESOLVE: stall_if_id=0; branch resolves; return to IDLE.
- Resolution cycle: pc_sel_branch = flush_if_id = beq_valid, each for exactly one cycle. Both are never asserted while stall_if_id=1.
- pipe_hold=1 overrides everything: FSM and counter frozen; stall_if_id=1; flush_if_id=0; pc_sel_branch=0.
- A non-branch or invalid ID instruction in IDLE produces all-zero outputs except the forwarding selects.
- Latency: taken branch with no hazard gives a 1-cycle penalty (flush); an EX load dependency gives 3 cycles.

Optional Feature:
- Macro: MIPS_BRANCH_STATS_EN.
- When defined: adds outputs stat_taken (32 bits) and stat_stall (32 bits).
  - stat_taken increments on each pc_sel_branch.
  - stat_stall increments on each branch-induced stall cycle; pipe_hold cycles are excluded.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- mips_pkg gains t_br_state (IDLE/STALL/RESOLVE, 2 bits) and t_fwd_sel (FWD_RF=00, FWD_MEM=01).
- Sub-module mips_branch_hazard_detect: combinational; per-operand hazard count and fwd_sel; instantiated twice (rs, rt).
- The FSM, counter and statistics live in the top module.

Test Plan:
- Branch rs=3, rt=4, no producers, beq_valid=1: same cycle pc_sel_branch=1, flush_if_id=1, stall_if_id=0; next cycle all 0.
- EX lw $5, branch rs=5, rt=0: stall_if_id=1 for 2 cycles, br_state 0→1→2, then in RESOLVE beq_valid=1 gives flush for 1 cycle.
- EX add $6, branch rt=6: 1 stall cycle, then RESOLVE with fwd_sel_b=01 (producer now in MEM).
- EX lw $7 and MEM add $7, branch rs=7: EX priority gives a 2-cycle stall; fwd_sel_a=00 during the detection cycle.
- pipe_hold=1 for 3 cycles mid-STALL: br_state and counter unchanged, flush=0; stall count resumes after release.
- rst_n=0 during STALL: next edge br_state=0, all outputs 0. With MIPS_BRANCH_STATS_EN, after scenario 2: stat_stall=2, stat_taken=1.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types for the MIPS ID-stage branch sequencer
package mips_pkg;

    // Branch sequencer states; encodings are visible on br_state for debug
    typedef enum logic [1:0] {
        BR_IDLE    = 2'd0,
        BR_STALL   = 2'd1,
        BR_RESOLVE = 2'd2
    } t_br_state;

    // Branch comparator operand source
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01
    } t_fwd_sel;

    // Largest hazard count the sequencer ever has to wait out
    localparam int MAX_BR_STALL = 2;

    // Larger of two unsigned stall counts
    function automatic logic [1:0] cnt_max2(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mips_branch_hazard_detect.sv
// rtl/mips_branch_hazard_detect.sv - per-operand branch hazard count and comparator forward select
module mips_branch_hazard_detect
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 2
) (
    input  logic [REG_ADDR_W-1:0] i_reg,
    input  logic                  i_ex_reg_write,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_mem_reg_write,
    input  logic                  i_mem_mem_read,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    output logic [CNT_W-1:0]      o_hazard_cnt,
    output t_fwd_sel              o_fwd_sel
);

    logic w_reg_nonzero;
    logic w_ex_match;
    logic w_mem_match;

    // $zero is hardwired, so a write to it never creates a dependency
    assign w_reg_nonzero = (i_reg != '0);
    assign w_ex_match    = w_reg_nonzero && i_ex_reg_write  && (i_ex_rd  == i_reg);
    assign w_mem_match   = w_reg_nonzero && i_mem_reg_write && (i_mem_rd == i_reg);

    // EX producer dominates MEM: the younger value is the one the branch needs.
    // An EX load needs two cycles (through MEM), an EX ALU op one cycle (then forwarded
    // from MEM), and a MEM load one cycle (then read from the write-before-read regfile).
    always_comb begin
        o_hazard_cnt = '0;
        if (w_ex_match) begin
            o_hazard_cnt = i_ex_mem_read ? CNT_W'(2) : CNT_W'(1);
        end else if (w_mem_match && i_mem_mem_read) begin
            o_hazard_cnt = CNT_W'(1);
        end
    end

    // A MEM ALU result is ready for the comparator unless an EX write shadows it
    always_comb begin
        o_fwd_sel = FWD_RF;
        if (w_mem_match && !i_mem_mem_read && !w_ex_match) begin
            o_fwd_sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/mips_branch_ctrl.sv
// rtl/mips_branch_ctrl.sv - ID-stage branch stall/forward/redirect sequencer; optional MIPS_BRANCH_STATS_EN counters
module mips_branch_ctrl
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_hold,
    input  logic                  id_valid,
    input  logic                  id_is_branch,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  beq_valid,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic                  pc_sel_branch,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
`ifdef MIPS_BRANCH_STATS_EN
    output logic [31:0]           stat_taken,
    output logic [31:0]           stat_stall,
`endif
    output logic [1:0]            br_state
);

    t_br_state          r_state;
    logic [CNT_W-1:0]   r_cnt;

    logic [CNT_W-1:0]   w_hz_a;
    logic [CNT_W-1:0]   w_hz_b;
    t_fwd_sel           w_fwd_a;
    t_fwd_sel           w_fwd_b;
    logic [CNT_W-1:0]   w_need;
    logic               w_branch;
    logic               w_stall;
    logic               w_redirect;

    mips_branch_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) u_hz_rs (
        .i_reg           (id_rs),
        .i_ex_reg_write  (ex_reg_write),
        .i_ex_mem_read   (ex_mem_read),
        .i_ex_rd         (ex_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_mem_read  (mem_mem_read),
        .i_mem_rd        (mem_rd),
        .o_hazard_cnt    (w_hz_a),
        .o_fwd_sel       (w_fwd_a)
    );

    mips_branch_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) u_hz_rt (
        .i_reg           (id_rt),
        .i_ex_reg_write  (ex_reg_write),
        .i_ex_mem_read   (ex_mem_read),
        .i_ex_rd         (ex_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_mem_read  (mem_mem_read),
        .i_mem_rd        (mem_rd),
        .o_hazard_cnt    (w_hz_b),
        .o_fwd_sel       (w_fwd_b)
    );

    assign w_branch = id_valid && id_is_branch;
    assign w_need   = (w_hz_a > w_hz_b) ? w_hz_a : w_hz_b;

    // Stall and redirect depend on the current decode in IDLE, so they stay combinational;
    // pipe_hold wins so a frozen pipeline never sees a redirect it would lose
    always_comb begin
        w_stall    = 1'b0;
        w_redirect = 1'b0;
        if (pipe_hold) begin
            w_stall = 1'b1;
        end else begin
            case (r_state)
                BR_IDLE: begin
                    if (w_branch && (w_need != '0)) begin
                        w_stall = 1'b1;
                    end else if (w_branch) begin
                        w_redirect = beq_valid;
                    end
                end
                BR_STALL:   w_stall    = 1'b1;
                BR_RESOLVE: w_redirect = beq_valid;
                default:    w_stall    = 1'b0;
            endcase
        end
    end

    // Sequencer: counts out the operand hazard, then gives the comparator one resolve cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BR_IDLE;
            r_cnt   <= '0;
        end else if (!pipe_hold) begin
            case (r_state)
                BR_IDLE: begin
                    if (w_branch && (w_need != '0)) begin
                        r_cnt   <= w_need - CNT_W'(1);
                        r_state <= (w_need == CNT_W'(MAX_BR_STALL)) ? BR_STALL : BR_RESOLVE;
                    end
                end
                BR_STALL: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= BR_RESOLVE;
                    end
                end
                BR_RESOLVE: begin
                    r_state <= BR_IDLE;
                end
                default: begin
                    r_state <= BR_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef MIPS_BRANCH_STATS_EN
    logic [31:0] r_stat_taken;
    logic [31:0] r_stat_stall;

    // Event counters; frozen-pipeline cycles are not branch stalls and are skipped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_taken <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_redirect) begin
                r_stat_taken <= r_stat_taken + 32'd1;
            end
            if (w_stall && !pipe_hold) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_taken = r_stat_taken;
    assign stat_stall = r_stat_stall;
`endif

    assign stall_if_id   = w_stall;
    assign flush_if_id   = w_redirect;
    assign pc_sel_branch = w_redirect;
    assign fwd_sel_a     = w_fwd_a;
    assign fwd_sel_b     = w_fwd_b;
    assign br_state      = r_state;

endmodule
